// File: rtl/add_rr_arbiter_pkg.sv
// Shared types for the round-robin adder arbiter: FSM states, requester
// index type and a one-hot helper used for the ack / rsp_valid vectors.
package add_rr_arbiter_pkg;

    localparam int N_REQ = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef logic [$clog2(N_REQ)-1:0] req_idx_t;

    // One-hot vector with only the bit of requester idx set.
    function automatic logic [N_REQ-1:0] idx_onehot(input req_idx_t idx);
        logic [N_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/add_rr_arbiter_rr_arb2.sv
// Two-way round-robin selector. A lone request wins outright; on a tie the
// requester that was not served last wins.
module rr_arb2
    import add_rr_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  req_idx_t         last_served,
    output req_idx_t         grant
);

    // Pick the winner from the request pattern and the last-served index.
    always_comb begin
        grant = '0;
        case (req)
            2'b01:   grant = req_idx_t'(0);
            2'b10:   grant = req_idx_t'(1);
            2'b11:   grant = ~last_served;
            default: grant = '0;
        endcase
    end

endmodule

// File: rtl/add_rr_arbiter.sv
// Arbitrates two requesters onto one external combinational adder.
// Handshake: a requester holds req and its operands until ack pulses; the
// result is then presented with rsp_valid[g] and held until rsp_ready[g]=1
// is seen at a rising edge, which completes the transfer.
module add_rr_arbiter
    import add_rr_arbiter_pkg::*;
#(
    parameter int W = 128
)
(
    input  logic             CLK_50,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic [W-1:0]     a0,
    input  logic [W-1:0]     b0,
    input  logic             cin0,
    input  logic [W-1:0]     a1,
    input  logic [W-1:0]     b1,
    input  logic             cin1,
    output logic [N_REQ-1:0] ack,
    output logic [N_REQ-1:0] rsp_valid,
    input  logic [N_REQ-1:0] rsp_ready,
    output logic [W-1:0]     rsp_s,
    output logic             rsp_cout,
    output logic [W-1:0]     add_a,
    output logic [W-1:0]     add_b,
    output logic             add_cin,
    input  logic [W-1:0]     add_s,
    input  logic             add_cout,
    output state_t           dbg_state
);

    state_t       state;
    state_t       state_next;
    req_idx_t     grant_q;
    req_idx_t     last_served;
    req_idx_t     arb_grant;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         op_cin;
    logic [W-1:0] rsp_s_q;
    logic         rsp_cout_q;

    rr_arb2 u_rr_arb2 (
        .req         (req),
        .last_served (last_served),
        .grant       (arb_grant)
    );

    // State register plus operand / result / last-served bookkeeping.
    always_ff @(posedge CLK_50) begin
        if (reset) begin
            state       <= IDLE;
            grant_q     <= '0;
            last_served <= req_idx_t'(1);  // requester 0 wins the first tie
            op_a        <= '0;
            op_b        <= '0;
            op_cin      <= 1'b0;
            rsp_s_q     <= '0;
            rsp_cout_q  <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (req != '0) begin
                        grant_q <= arb_grant;
                        op_a    <= arb_grant[0] ? a1   : a0;
                        op_b    <= arb_grant[0] ? b1   : b0;
                        op_cin  <= arb_grant[0] ? cin1 : cin0;
                    end
                end
                EXEC: begin
                    rsp_s_q    <= add_s;
                    rsp_cout_q <= add_cout;
                end
                RESP: begin
                    if (rsp_ready[grant_q]) begin
                        last_served <= grant_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state and handshake outputs; ack is the single EXEC cycle.
    always_comb begin
        state_next = state;
        ack        = '0;
        rsp_valid  = '0;
        case (state)
            IDLE: begin
                if (req != '0) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                ack        = idx_onehot(grant_q);
                state_next = RESP;
            end
            RESP: begin
                rsp_valid = idx_onehot(grant_q);
                if (rsp_ready[grant_q]) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign add_a     = op_a;
    assign add_b     = op_b;
    assign add_cin   = op_cin;
    assign rsp_s     = rsp_s_q;
    assign rsp_cout  = rsp_cout_q;
    assign dbg_state = state;

endmodule
